// File: rtl/pattern_history_table.sv
// Second-level branch predictor: 2-bit saturating counters indexed by PC^history.
// Runs an array init sweep after reset, then predicts and retires updates two un-stalled cycles after lookup.
module pattern_history_table #(
    parameter int         PHT_ADDR_W = 8,
    parameter int         BHR_W      = 8,
    parameter logic [1:0] INIT_CNT   = 2'b01
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic [31:0]      pc_i,
    input  logic [BHR_W-1:0] bhr_i,
    input  logic             branch_info_valid,
    input  logic             branch_dir_i,
    output logic             predict_taken_o,
    output logic             predict_valid_o,
    output logic             init_busy_o
);
    // state  | meaning
    // INIT   | sweeping INIT_CNT into every counter, one entry per cycle
    // RUN    | predicting and applying resolved-branch updates
    localparam int DEPTH = 1 << PHT_ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PHT_ADDR_W-1:0] r_init_ptr;
    logic [PHT_ADDR_W-1:0] w_init_ptr_nxt;
    logic [PHT_ADDR_W-1:0] r_idx_buf0;
    logic [PHT_ADDR_W-1:0] r_idx_buf1;
    logic [1:0]            r_cnt [DEPTH];

    logic [PHT_ADDR_W-1:0] w_idx;
    logic [1:0]            w_upd_cnt;
    logic                  w_run;
    logic                  w_we;
    logic [PHT_ADDR_W-1:0] w_waddr;
    logic [1:0]            w_wdata;
    logic                  w_unused;

    assign w_idx     = pc_i[PHT_ADDR_W+1:2] ^ bhr_i;
    assign w_upd_cnt = r_cnt[r_idx_buf1];
    assign w_run     = (r_state == ST_RUN);
    assign w_unused  = ^{pc_i[31:PHT_ADDR_W+2], pc_i[1:0]};

    assign predict_valid_o = resetn && w_run;
    assign init_busy_o     = !predict_valid_o;
    assign predict_taken_o = predict_valid_o && r_cnt[w_idx][1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
            r_idx_buf0 <= '0;
            r_idx_buf1 <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
            if (w_run && !stall) begin
                r_idx_buf0 <= w_idx;
                r_idx_buf1 <= r_idx_buf0;
            end
        end
    end

    // Init sweep and branch updates share the one write port; they never overlap.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        w_we           = 1'b0;
        w_waddr        = r_init_ptr;
        w_wdata        = INIT_CNT;
        case (r_state)
            ST_INIT: begin
                w_we           = 1'b1;
                w_init_ptr_nxt = r_init_ptr + PHT_ADDR_W'(1);
                if (r_init_ptr == {PHT_ADDR_W{1'b1}}) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall && branch_info_valid) begin
                    w_we    = 1'b1;
                    w_waddr = r_idx_buf1;
                    if (branch_dir_i) begin
                        w_wdata = (w_upd_cnt == 2'b11) ? 2'b11 : w_upd_cnt + 2'd1;
                    end else begin
                        w_wdata = (w_upd_cnt == 2'b00) ? 2'b00 : w_upd_cnt - 2'd1;
                    end
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn && w_we) begin
            r_cnt[w_waddr] <= w_wdata;
        end
    end
endmodule
